pipelined_core_ctrl: RTL and testbench

- Sequencer for the pipelined vector processing core. Accepts one command at a time: read, sum, avg or manhattan.
- Drives the core's one-hot operation enables, memory select, PISO load/shift and manhattan-capture strobes, waiting out each op's pipeline latency.
- Presents results as a valid/ready stream: NINPUTS elements for parallel ops, one scalar for manhattan. Pulses op_done on completion.
- Sits between the command decoder and the processing core.

---
 rtl/pipelined_core_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_pipelined_core_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_core_ctrl.sv
// -----------------------------------------------------------------------------
// pipelined_core_ctrl
//
// Sequencer for the pipelined vector processing core. It accepts one command at
// a time (read / sum / avg / manhattan) and drives the core's one-hot operation
// enables and memory select. It waits out the pipeline latency of the selected
// op, then loads and shifts the PISO or captures the manhattan register. Results
// leave on a valid/ready stream: NINPUTS elements for parallel ops, or a single
// scalar for manhattan.
//
// Ports
//   clk            clock
//   reset          asynchronous active-low reset
//   cmd_valid/ready command handshake (cmd_ready is high only in IDLE)
//   cmd_op [2:0]   0=read 1=sum 2=avg 4=manhattan, anything else is illegal
//   cmd_sel        read source (1=A, 0=B)
//   enables [5:0]  one-hot op enable: bit0 read, bit1 sum, bit2 avg, bit4 man
//   read_mem_sel   registered cmd_sel
//   load_piso      one-cycle PISO parallel load
//   shift_mem      PISO shift strobe (high on each accepted stream element)
//   update_man     one-cycle manhattan register capture
//   out_valid/ready/last  result stream
//   op_done        one-cycle completion pulse
//   cmd_err        one-cycle pulse after an illegal opcode is accepted
//   perf_cycles    cycles taken by the last op
//
// Optional feature
//   PIPE_CTRL_PERF_CNT_EN : when defined, perf_cycles reports the number of
//   cycles from command accept through the DONE cycle inclusive, saturating at
//   32'hFFFF_FFFF. When undefined, perf_cycles is tied to 0.
// -----------------------------------------------------------------------------
// state    | meaning
// ---------+------------------------------------------------------------------
// S_IDLE   | ready for a command
// S_WAIT   | waiting out the op's pipeline latency
// S_LOAD   | parallel-load the PISO with the op result
// S_STREAM | stream NINPUTS elements out of the PISO
// S_MCAP   | capture the adder-tree output into the manhattan register
// S_MOUT   | present the manhattan scalar
// S_DONE   | completion pulse; enables cleared
// -----------------------------------------------------------------------------
module pipelined_core_ctrl #(
   parameter int NINPUTS = 1024,
   parameter int SUM_LAT = 1,
   parameter int AVG_LAT = 2,
   parameter int MAN_LAT = 11
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic        cmd_sel,
   output logic [5:0]  enables,
   output logic        read_mem_sel,
   output logic        load_piso,
   output logic        shift_mem,
   output logic        update_man,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        op_done,
   output logic        cmd_err,
   output logic [31:0] perf_cycles
);

   localparam int IDX_W   = (NINPUTS > 1) ? $clog2(NINPUTS) : 1;
   localparam int MAX_SA  = (SUM_LAT > AVG_LAT) ? SUM_LAT : AVG_LAT;
   localparam int MAX_LAT = (MAX_SA > MAN_LAT) ? MAX_SA : MAN_LAT;
   localparam int WAIT_W  = (MAX_LAT > 1) ? $clog2(MAX_LAT + 1) : 1;

   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NINPUTS - 1);
   localparam logic [WAIT_W-1:0] WAIT_TC  = WAIT_W'(1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_LOAD   = 3'd2;
   localparam logic [2:0] S_STREAM = 3'd3;
   localparam logic [2:0] S_MCAP   = 3'd4;
   localparam logic [2:0] S_MOUT   = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [IDX_W-1:0]  idx;
   logic [5:0]        en_q;
   logic              sel_q;
   logic              err_q;

   logic              accept;
   logic              op_legal;
   logic [5:0]        en_dec;
   logic [WAIT_W-1:0] lat_dec;

   assign accept = cmd_valid & cmd_ready;

   always_comb begin
      en_dec   = '0;
      lat_dec  = '0;
      op_legal = 1'b1;
      case (cmd_op)
         3'd0:    en_dec[0] = 1'b1;
         3'd1: begin
            en_dec[1] = 1'b1;
            lat_dec   = WAIT_W'(SUM_LAT);
         end
         3'd2: begin
            en_dec[2] = 1'b1;
            lat_dec   = WAIT_W'(AVG_LAT);
         end
         3'd4: begin
            en_dec[4] = 1'b1;
            lat_dec   = WAIT_W'(MAN_LAT);
         end
         default: op_legal = 1'b0;
      endcase
   end

   // A latency of L occupies max(L,1) WAIT cycles: the counter is loaded with L
   // and WAIT is left once it is at or below one, so a zero-latency read still
   // spends exactly one cycle there.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (accept && op_legal) state_nxt = S_WAIT;
         S_WAIT:   if (wait_cnt <= WAIT_TC) state_nxt = en_q[4] ? S_MCAP : S_LOAD;
         S_LOAD:   state_nxt = S_STREAM;
         S_STREAM: if (out_ready && (idx == LAST_IDX)) state_nxt = S_DONE;
         S_MCAP:   state_nxt = S_MOUT;
         S_MOUT:   if (out_ready) state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
         idx      <= '0;
         en_q     <= '0;
         sel_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         err_q <= accept & ~op_legal;
         case (state)
            S_IDLE: begin
               if (accept && op_legal) begin
                  en_q     <= en_dec;
                  sel_q    <= cmd_sel;
                  wait_cnt <= lat_dec;
               end
            end
            S_WAIT: begin
               if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
            end
            S_LOAD: idx <= '0;
            S_STREAM: begin
               if (out_ready && (idx != LAST_IDX)) idx <= idx + 1'b1;
            end
            S_DONE: begin
               en_q  <= '0;
               sel_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Strobes are decoded from the state so an asynchronous reset drops them
   // immediately rather than one edge later.
   assign cmd_ready    = (state == S_IDLE);
   assign enables      = en_q;
   assign read_mem_sel = sel_q;
   assign load_piso    = (state == S_LOAD);
   assign shift_mem    = (state == S_STREAM) & out_ready;
   assign update_man   = (state == S_MCAP);
   assign out_valid    = (state == S_STREAM) | (state == S_MOUT);
   assign out_last     = ((state == S_STREAM) & (idx == LAST_IDX)) | (state == S_MOUT);
   assign op_done      = (state == S_DONE);
   assign cmd_err      = err_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
   logic [31:0] perf_cnt;
   logic [31:0] perf_q;

   // perf_cnt reads (cycles since accept - 1) during an op, so the DONE cycle
   // itself is folded in when the result is latched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_cnt <= '0;
         perf_q   <= '0;
      end else begin
         if (accept) begin
            perf_cnt <= '0;
         end else if ((state != S_IDLE) && (perf_cnt != '1)) begin
            perf_cnt <= perf_cnt + 32'd1;
         end
         if (state == S_DONE) begin
            perf_q <= (perf_cnt == '1) ? '1 : perf_cnt + 32'd1;
         end
      end
   end

   assign perf_cycles = perf_q;
`else
   assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_pipelined_core_ctrl.sv
`timescale 1ns/1ps
module tb_pipelined_core_ctrl;

   localparam int N       = 4;
   localparam int SUM_LAT = 1;
   localparam int AVG_LAT = 2;
   localparam int MAN_LAT = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic        cmd_sel;
   logic [5:0]  enables;
   logic        read_mem_sel;
   logic        load_piso;
   logic        shift_mem;
   logic        update_man;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        op_done;
   logic        cmd_err;
   logic [31:0] perf_cycles;

   pipelined_core_ctrl #(
      .NINPUTS (N),
      .SUM_LAT (SUM_LAT),
      .AVG_LAT (AVG_LAT),
      .MAN_LAT (MAN_LAT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_sel      (cmd_sel),
      .enables      (enables),
      .read_mem_sel (read_mem_sel),
      .load_piso    (load_piso),
      .shift_mem    (shift_mem),
      .update_man   (update_man),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_last     (out_last),
      .op_done      (op_done),
      .cmd_err      (cmd_err),
      .perf_cycles  (perf_cycles)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_event(input string name);
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s: event seen/missing at cycle %0d", name, cyc);
   endtask

   // expected response of one command
   typedef struct {
      bit         err;
      bit         man;
      int         delay;   // accept cycle -> first strobe (cmd_err/load_piso/update_man)
      logic [5:0] en;
      bit         sel;
      int         nel;     // elements streamed
      int         gap;     // accept cycle - previous op_done cycle, -1 = unchecked
      int         total;   // accept cycle -> op_done cycle, -1 = unchecked
   } exp_t;

   exp_t exp_q[$];

   function automatic exp_t mk(bit err, bit man, int delay, logic [5:0] en, bit sel,
                               int nel, int gap, int total);
      exp_t e;
      e.err = err; e.man = man; e.delay = delay; e.en = en; e.sel = sel;
      e.nel = nel; e.gap = gap; e.total = total;
      return e;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   exp_t cur;
   exp_t e_pop;
   bit   trk = 0;
   bit   perf_pend = 0;
   bit   man_next = 0;
   int   acc_cyc = 0;
   int   last_done = -100;
   int   nel = 0;
   int   exp_perf = 0;

   always @(negedge clk) begin
      if (!reset) begin
         trk       = 0;
         perf_pend = 0;
         man_next  = 0;
      end else begin
         if (perf_pend) begin
            chk("perf_cycles", perf_cycles, exp_perf);
            chk("enables_cleared", enables, 0);
            chk("sel_cleared", read_mem_sel, 0);
            perf_pend = 0;
         end
         if (man_next) begin
            chk("man_out_valid", out_valid, 1);
            chk("man_out_last", out_last, 1);
            man_next = 0;
         end
         if (cmd_valid && cmd_ready) acc_cyc = cyc;

         chk("strobe_onehot", ($countones({load_piso, shift_mem, update_man}) <= 1), 1);
         if (!out_ready) chk("shift_without_ready", shift_mem, 0);

         if (cmd_err || load_piso || update_man) begin
            if (exp_q.size() == 0) begin
               fail_event("unexpected_response");
            end else begin
               e_pop = exp_q.pop_front();
               chk("resp_cmd_err", cmd_err, e_pop.err);
               chk("resp_update_man", update_man, (!e_pop.err && e_pop.man));
               chk("resp_delay", cyc - acc_cyc, e_pop.delay);
               chk("enables", enables, e_pop.en);
               if (e_pop.gap >= 0) chk("accept_gap", acc_cyc - last_done, e_pop.gap);
               if (e_pop.err) begin
                  chk("err_cmd_ready", cmd_ready, 1);
               end else begin
                  chk("read_mem_sel", read_mem_sel, e_pop.sel);
                  cur      = e_pop;
                  trk      = 1;
                  nel      = 0;
                  man_next = e_pop.man;
               end
            end
         end

         if (out_valid && out_ready) begin
            if (!trk) begin
               fail_event("unexpected_element");
            end else begin
               chk("out_last", out_last, (nel == cur.nel - 1));
               chk("shift_mem", shift_mem, !cur.man);
               chk("enables_stable", enables, cur.en);
               nel = nel + 1;
            end
         end
         if (trk && cur.man) chk("man_no_shift", shift_mem, 0);

         if (op_done) begin
            if (!trk) begin
               fail_event("unexpected_op_done");
            end else begin
               chk("element_count", nel, cur.nel);
               chk("done_enables", enables, cur.en);
               if (cur.total >= 0) chk("done_latency", cyc - acc_cyc, cur.total);
`ifdef PIPE_CTRL_PERF_CNT_EN
               exp_perf = cyc - acc_cyc;
`else
               exp_perf = 0;
`endif
               perf_pend = 1;
               last_done = cyc;
               trk       = 0;
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_accept();
      int n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) fail_event("accept_timeout");
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic sel, input exp_t e, input bit hold);
      exp_q.push_back(e);
      cmd_op    = op;
      cmd_sel   = sel;
      cmd_valid = 1'b1;
      wait_accept();
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || trk || perf_pend) && n < 300) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0 || trk) fail_event("op_timeout");
      cycles(2);
   endtask

   initial begin
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_sel   = 1'b0;
      out_ready = 1'b0;
      #12;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_enables", enables, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_op_done", op_done, 0);
      chk("rst_cmd_err", cmd_err, 0);
      chk("rst_strobes", {load_piso, shift_mem, update_man, out_last, read_mem_sel}, 0);
      chk("rst_perf", perf_cycles, 0);
      @(negedge clk);
      reset = 1'b1;
      cycles(1);

      // read from A, always ready
      out_ready = 1'b1;
      issue(3'd0, 1'b1, mk(0, 0, 2, 6'b000001, 1, N, -1, 7), 0);
      wait_idle();

      // avg with out_ready toggling 0,1,0,1... from the cycle after accept
      issue(3'd2, 1'b0, mk(0, 0, 3, 6'b000100, 0, N, -1, 11), 0);
      repeat (20) begin
         out_ready = ~out_ready;
         cycles(1);
      end
      out_ready = 1'b1;
      wait_idle();

      // manhattan, scalar held until ready rises
      out_ready = 1'b0;
      issue(3'd4, 1'b0, mk(0, 1, 4, 6'b010000, 0, 1, -1, 9), 0);
      cycles(7);
      out_ready = 1'b1;
      wait_idle();

      // illegal opcode
      issue(3'd3, 1'b1, mk(1, 0, 1, 6'b000000, 0, 0, -1, -1), 0);
      wait_idle();
      chk("err_idle_ready", cmd_ready, 1);
      chk("err_enables", enables, 0);

      // sum followed by a read with cmd_valid held high throughout
      issue(3'd1, 1'b0, mk(0, 0, 2, 6'b000010, 0, N, -1, 7), 1);
      issue(3'd0, 1'b0, mk(0, 0, 2, 6'b000001, 0, N, 1, 7), 0);
      wait_idle();

      // reset asserted while streaming element index 2
      issue(3'd0, 1'b1, mk(0, 0, 2, 6'b000001, 1, N, -1, -1), 0);
      cycles(4);
      chk("mid_stream_valid", out_valid, 1);
      chk("mid_stream_last", out_last, 0);
      #1 reset = 1'b0;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_enables", enables, 0);
      chk("abort_strobes", {load_piso, shift_mem, update_man, out_last, read_mem_sel, op_done}, 0);
      chk("abort_cmd_ready", cmd_ready, 1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      cycles(1);
      chk("post_abort_ready", cmd_ready, 1);
      cycles(10);

      // recovery: sum from A
      issue(3'd1, 1'b1, mk(0, 0, 2, 6'b000010, 1, N, -1, 7), 0);
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
